vga_framebuffer_arbiter: RTL

Shares the single-port framebuffer SRAM between two requesters: display scan-out reads, driven by the VGA timing block's address and display-enable, and a pixel-writer stream (valid/ready). Display reads have absolute priority on pixel-strobe cycles. All other cycles, including blanking, are available to writes. Sits between the VGA timing top module, the pixel producer and the framebuffer memory.

---
 rtl/vga_framebuffer_arbiter_if.sv | 35 +++
 rtl/vga_framebuffer_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vga_framebuffer_arbiter_if.sv
// Bus interfaces for the framebuffer arbiter.
//
// vga_fb_wr_if : pixel-writer stream (valid/ready handshake).
//   master = pixel producer : drives valid, addr, data; receives ready
//   slave  = arbiter        : receives valid, addr, data; drives ready
//
// vga_fb_mem_if : single-port framebuffer SRAM bus.
//   master = arbiter : drives addr, wdata, we; receives rdata
//   slave  = SRAM    : receives addr, wdata, we; drives rdata

interface vga_fb_wr_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

interface vga_fb_mem_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/vga_framebuffer_arbiter.sv
// Framebuffer SRAM arbiter between VGA scan-out reads and a pixel-writer
// stream. Display reads own every pixel-strobe cycle with display enable
// asserted; every other cycle (including blanking) is available to writes.
//
// Ports:
//   clk, rst          : system clock (2x pixel clock), async active-high reset
//   pix_ce            : one-cycle pixel strobe from the timing block
//   disp_en           : display enable from the timing block
//   disp_addr         : scan-out address
//   disp_pixel        : pixel to DAC (0 during blanking)
//   disp_pixel_valid  : disp_pixel carries framebuffer data
//   wr  (slave)       : pixel-writer stream valid/ready/addr/data
//   mem (master)      : registered SRAM addr/wdata/we, read data return
//   stall_clr         : synchronous clear of stall_cnt and err_oob
//   stall_cnt         : saturating count of stalled writer cycles
//   err_oob           : sticky, an out-of-range write was accepted

module vga_framebuffer_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int FB_SIZE = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_pixel,
  output logic              disp_pixel_valid,
  vga_fb_wr_if.slave        wr,
  vga_fb_mem_if.master      mem,
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
  output logic              err_oob
);

  // One stage for the registered address, RD_LAT stages for the SRAM.
  localparam int PIPE = 1 + RD_LAT;
  localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_SIZE);

  logic              disp_slot;
  logic              xfer;
  logic              wr_oob;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  // tok_live marks a pixel-strobe token in flight; tok_data says whether it
  // is a real read (1) or a blank (0). Both travel together so the display
  // latency is identical for data and blanking.
  logic [PIPE-1:0]   tok_live;
  logic [PIPE-1:0]   tok_data;

  logic [DATA_W-1:0] disp_pixel_q;
  logic              disp_pixel_valid_q;
  logic [15:0]       stall_cnt_q;
  logic              err_oob_q;

  assign disp_slot = pix_ce & disp_en;
  assign wr.ready  = ~disp_slot & ~rst;
  assign xfer      = wr.valid & wr.ready;
  assign wr_oob    = ({1'b0, wr.addr} >= FB_LIMIT);

  // SRAM command register. An out-of-range write completes its handshake
  // but never strobes the SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (disp_slot) begin
        mem_addr_q <= disp_addr;
      end else if (xfer) begin
        mem_addr_q  <= wr.addr;
        mem_wdata_q <= wr.data;
        mem_we_q    <= ~wr_oob;
      end
    end
  end

  // Read token pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_live <= '0;
      tok_data <= '0;
    end else begin
      tok_live <= {tok_live[PIPE-2:0], pix_ce};
      tok_data <= {tok_data[PIPE-2:0], disp_en};
    end
  end

  // Display output register; holds between tokens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_pixel_q       <= '0;
      disp_pixel_valid_q <= 1'b0;
    end else if (tok_live[PIPE-1]) begin
      disp_pixel_q       <= tok_data[PIPE-1] ? mem.rdata : '0;
      disp_pixel_valid_q <= tok_data[PIPE-1];
    end
  end

  // Status: clear wins over both the stall increment and the oob flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      err_oob_q   <= 1'b0;
    end else if (stall_clr) begin
      stall_cnt_q <= '0;
      err_oob_q   <= 1'b0;
    end else begin
      if (wr.valid && !wr.ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (xfer && wr_oob)
        err_oob_q <= 1'b1;
    end
  end

  assign mem.addr         = mem_addr_q;
  assign mem.wdata        = mem_wdata_q;
  assign mem.we           = mem_we_q;
  assign disp_pixel       = disp_pixel_q;
  assign disp_pixel_valid = disp_pixel_valid_q;
  assign stall_cnt        = stall_cnt_q;
  assign err_oob          = err_oob_q;

endmodule
